mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory of the KGP-RISC CPU between two requesters: the instruction-fetch path (IF) and the load/store path (DM).
- Sits between the CPU datapath and the memory macro.
- Arbitrates between the two, sequences each access through a fixed-latency memory, and returns read data or a write acknowledge to the winner.
- One transaction is outstanding at a time. DM has priority, with a starvation guard for IF.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the issue cycle (mem_en=1) to mem_rdata valid; legal range >=1
STARVE_MAX, 4, consecutive DM wins while IF is waiting before IF is forced to win; legal range >=1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle accept pulse for the fetch request
if_rvalid  out  1  one-cycle pulse; if_rdata is valid
if_rdata  out  DATA_W  fetched instruction word, registered
dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata stable until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle accept pulse for the data request
dm_rvalid  out  1  one-cycle pulse; load data valid or store complete
dm_rdata  out  DATA_W  load data, registered
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:

Reset:
- While rst=0, asynchronously: state=IDLE, wait counter=0, starve counter=0.
- All outputs are 0, including the registered rdata/addr/wdata.
- An in-flight transaction is dropped silently: no rvalid is ever produced for it.
- Operation resumes on the first rising edge after rst returns to 1.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Select a winner combinationally:
  - DM wins if dm_req=1, unless starve counter==STARVE_MAX and if_req=1, in which case IF wins.
  - Otherwise IF wins if if_req=1.
- The winner's gnt=1 in this cycle; the other gnt=0.
- gnt is only ever asserted in IDLE.
- At the clock edge: latch the owner, address, we (forced to 0 for IF) and wdata; go to ISSUE.
- Starve counter:
  - If DM wins while if_req=1: increment, saturating at STARVE_MAX.
  - If IF wins: clear to 0.
  - Otherwise: hold.

ISSUE (1 cycle):
- mem_en=1; mem_we = latched we; mem_addr and mem_wdata driven from the latched registers.
- Load wait counter with MEM_LAT-1; go to WAIT. If MEM_LAT==1, go directly to the capture point below.

WAIT:
- Decrement the counter each cycle; mem_en=0.
- When the counter reaches 0, mem_rdata is valid in that cycle.
- Capture mem_rdata into the owner's rdata register; a store leaves rdata unchanged.
- Go to RESP.

RESP (1 cycle):
- Owner's rvalid=1. For a store, dm_rvalid is the write acknowledge.
- Next state is IDLE.

Latency:
- gnt (cycle 0) to rvalid is MEM_LAT+2 cycles.
- The next gnt is possible at cycle MEM_LAT+3.
- With MEM_LAT=2: gnt@0, mem_en@1, capture@3, rvalid@4, next gnt@5.

Request rules:
- Requests arriving while busy=1 are ignored until IDLE. The requester must keep req asserted.
- Dropping req before gnt withdraws it with no side effect.

Other:
- mem_addr and mem_wdata hold their last values outside ISSUE.
- mem_we is 0 whenever mem_en=0.
- No arithmetic on data. The wait counter width is clog2(MEM_LAT+1).

Test Plan:
- Reset, then if_req=1, if_addr=0x00000010, memory returns 0xDEADBEEF, MEM_LAT=2 -> if_gnt @ cycle 0, mem_en=1 with mem_addr=0x10 @ cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF @ cycle 4, busy low from cycle 5.
- Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0x12345678 -> mem_en=mem_we=1 with mem_addr=0x40 and mem_wdata=0x12345678 in the issue cycle; dm_rvalid pulse at gnt+4; dm_rdata unchanged.
- if_req and dm_req both asserted in the same IDLE cycle -> dm_gnt first; if_gnt 5 cycles later; no overlap of rvalids.
- if_req and dm_req both held continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; starve counter never exceeds 4.
- rst driven to 0 during WAIT of a load -> all outputs 0 immediately (async); after release, no dm_rvalid for the dropped load; a new request is granted normally.
- MEM_LAT=1 build: single load -> rvalid at gnt+3; mem_rdata sampled exactly 1 cycle after mem_en.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// requester (IF) and the load/store requester (DM). One transaction is in
// flight at a time. DM normally wins, but once IF has lost STARVE_MAX
// consecutive arbitrations, IF is forced to win the next one.
//
// State  | meaning
// IDLE   | arbitrate; the winner's gnt pulses and its request is latched
// ISSUE  | mem_en=1 for one cycle with the latched address/we/wdata
// WAIT   | count down the memory latency; capture mem_rdata when count hits 0
// RESP   | owner's rvalid pulses for one cycle (store: write acknowledge)
//
// Ports
//   clk, rst                     clock, async active-low reset
//   if_req/if_addr/if_gnt        fetch request, address, accept pulse
//   if_rvalid/if_rdata           fetch data return
//   dm_req/dm_we/dm_addr/dm_wdata/dm_gnt  data request and accept pulse
//   dm_rvalid/dm_rdata           load data return or store acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro interface
//   busy                         high whenever not IDLE
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              owner_dm;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_dm, pick_if;

    always_comb begin
        state_nxt = state;
        pick_dm   = 1'b0;
        pick_if   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !(starve_cnt == STARVE_TOP && if_req)) begin
                    pick_dm = 1'b1;
                end else if (if_req) begin
                    pick_if = 1'b1;
                end
                if (pick_dm || pick_if) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State is IDLE while reset is held, so the grant pick can be live;
    // gate it so no gnt escapes during reset.
    assign dm_gnt    = pick_dm & rst;
    assign if_gnt    = pick_if & rst;
    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);
    assign dm_rvalid = (state == RESP) &  owner_dm;
    assign if_rvalid = (state == RESP) & ~owner_dm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_dm   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if (pick_dm) begin
                owner_dm <= 1'b1;
                we_q     <= dm_we;
                addr_q   <= dm_addr;
                wdata_q  <= dm_wdata;
            end else if (pick_if) begin
                owner_dm <= 1'b0;
                we_q     <= 1'b0;
                addr_q   <= if_addr;
            end

            if (pick_dm && if_req && starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + SW'(1);
            end else if (pick_if) begin
                starve_cnt <= '0;
            end

            // Loading MEM_LAT-1 makes the zero-count WAIT cycle coincide
            // with mem_rdata valid; MEM_LAT==1 lands there directly.
            if (state == ISSUE) begin
                wait_cnt <= LAT_LOAD;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end

            if (state == WAIT && wait_cnt == '0 && !we_q) begin
                if (owner_dm) begin
                    dm_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
